// File: rtl/capture_scheduler_if.sv
// Stream bundle shared by the channel FIFOs, the capture scheduler and the packetizer.
interface capture_scheduler_if #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int USER_W = 8
);
   logic [NUM_CH*DATA_W-1:0] ch_tdata;
   logic [NUM_CH-1:0]        ch_tvalid;
   logic [NUM_CH-1:0]        ch_tready;
   logic [DATA_W-1:0]        m_tdata;
   logic [USER_W-1:0]        m_tuser;
   logic                     m_tvalid;
   logic                     m_tlast;
   logic                     m_tready;

   // master is the scheduler; slave is the channel sources together with the packetizer
   modport master (
      input  ch_tdata, ch_tvalid, m_tready,
      output ch_tready, m_tdata, m_tuser, m_tvalid, m_tlast
   );
   modport slave (
      output ch_tdata, ch_tvalid, m_tready,
      input  ch_tready, m_tdata, m_tuser, m_tvalid, m_tlast
   );
endinterface

// File: rtl/capture_scheduler.sv
// Round-robin capture sequencer: grants one channel per capture, forwards a fixed
// number of samples with tlast, and holds the packet sideband until pkt_done.
module capture_scheduler #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 32,
   parameter int USER_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [31:0]            timestamp_in,
   input  logic [7:0]             capture_len_cfg,
   input  logic [NUM_CH-1:0]      ch_overflow,
   input  logic                   pkt_done,
   capture_scheduler_if.master    bus,
   output logic [31:0]            timestamp_latched,
   output logic [7:0]             capture_len_out,
   output logic [15:0]            error_flags,
   output logic                   busy,
   output logic [15:0]            pkt_count
);
   localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {IDLE, ARB, STREAM, WAIT_DONE} state_t;

   state_t            state_reg;
   logic [GW-1:0]     grant_reg;
   logic [GW-1:0]     last_grant_reg;
   logic [8:0]        count_reg;
   logic [8:0]        target_reg;
   logic [NUM_CH-1:0] sticky_reg;
   logic              en_low_reg;
   logic [31:0]       ts_reg;
   logic [7:0]        len_reg;
   logic [15:0]       flags_reg;
   logic [15:0]       pkt_count_reg;

   logic              win;
   logic [GW-1:0]     winner;
   logic [GW-1:0]     cand;
   logic              latch;
   logic              beat;
   logic              last_beat;
   logic [15:0]       flags_next;

   // Rotating priority: the channel after the last grant is searched first
   always_comb begin
      win    = 1'b0;
      winner = last_grant_reg;
      cand   = last_grant_reg;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = GW'((int'(last_grant_reg) + k) % NUM_CH);
         if (!win && bus.ch_tvalid[cand]) begin
            win    = 1'b1;
            winner = cand;
         end
      end
   end

   assign latch     = (state_reg == ARB) && win;
   assign beat      = (state_reg == STREAM) && bus.ch_tvalid[grant_reg] && bus.m_tready;
   assign last_beat = (count_reg == target_reg - 9'd1);

   always_comb begin
      flags_next                = '0;
      flags_next[NUM_CH-1:0]    = sticky_reg | ch_overflow;
      flags_next[8]             = (ts_reg > timestamp_in);
      flags_next[9]             = en_low_reg;
   end

   always_comb begin
      bus.m_tvalid = 1'b0;
      bus.m_tdata  = '0;
      bus.m_tuser  = '0;
      bus.m_tlast  = 1'b0;
      if (state_reg == STREAM) begin
         bus.m_tvalid = bus.ch_tvalid[grant_reg];
         bus.m_tdata  = bus.ch_tdata[int'(grant_reg)*DATA_W +: DATA_W];
         bus.m_tuser  = USER_W'(grant_reg);
         bus.m_tlast  = last_beat;
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
      assign bus.ch_tready[gi] = (state_reg == STREAM) && (grant_reg == GW'(gi)) && bus.m_tready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GW'(NUM_CH - 1);
         count_reg      <= '0;
         target_reg     <= '0;
         sticky_reg     <= '0;
         en_low_reg     <= 1'b0;
         ts_reg         <= '0;
         len_reg        <= '0;
         flags_reg      <= '0;
         pkt_count_reg  <= '0;
      end else begin
         // An overflow in the latch cycle belongs to the packet being latched
         sticky_reg <= latch ? '0 : (sticky_reg | ch_overflow);
         case (state_reg)
            IDLE: begin
               if (enable)
                  state_reg <= ARB;
            end
            ARB: begin
               if (win) begin
                  grant_reg      <= winner;
                  last_grant_reg <= winner;
                  ts_reg         <= timestamp_in;
                  len_reg        <= capture_len_cfg;
                  target_reg     <= (capture_len_cfg == 8'd0) ? 9'd256 : {1'b0, capture_len_cfg};
                  count_reg      <= '0;
                  flags_reg      <= flags_next;
                  en_low_reg     <= 1'b0;
                  state_reg      <= STREAM;
               end else if (!enable) begin
                  state_reg <= IDLE;
               end
            end
            STREAM: begin
               if (!enable)
                  en_low_reg <= 1'b1;
               if (beat) begin
                  if (last_beat) begin
                     count_reg <= '0;
                     state_reg <= WAIT_DONE;
                  end else begin
                     count_reg <= count_reg + 9'd1;
                  end
               end
            end
            WAIT_DONE: begin
               if (pkt_done) begin
                  pkt_count_reg <= pkt_count_reg + 16'd1;
                  state_reg     <= enable ? ARB : IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign timestamp_latched = ts_reg;
   assign capture_len_out   = len_reg;
   assign error_flags       = flags_reg;
   assign busy              = (state_reg != IDLE);
   assign pkt_count         = pkt_count_reg;
endmodule

// File: tb/tb_capture_scheduler.sv
// Randomized bench for capture_scheduler with a transaction-level reference model.
module tb_capture_scheduler;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 32;
   localparam int USER_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [31:0]       timestamp_in;
   logic [7:0]        capture_len_cfg;
   logic [NUM_CH-1:0] ch_overflow;
   logic              pkt_done;
   logic [31:0]       timestamp_latched;
   logic [7:0]        capture_len_out;
   logic [15:0]       error_flags;
   logic              busy;
   logic [15:0]       pkt_count;

   capture_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .USER_W(USER_W)) bus ();

   capture_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .timestamp_in      (timestamp_in),
      .capture_len_cfg   (capture_len_cfg),
      .ch_overflow       (ch_overflow),
      .pkt_done          (pkt_done),
      .bus               (bus),
      .timestamp_latched (timestamp_latched),
      .capture_len_out   (capture_len_out),
      .error_flags       (error_flags),
      .busy              (busy),
      .pkt_count         (pkt_count)
   );

   always #5 clk = ~clk;

   // Each channel source emits {channel id, running sequence number}
   int seq [NUM_CH];
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_src
      assign bus.ch_tdata[gi*DATA_W +: DATA_W] = {8'(gi), seq[gi][23:0]};
   end

   int n_vec = 0;
   int n_err = 0;

   int                m_last;
   logic [NUM_CH-1:0] m_sticky;
   logic [31:0]       m_prev_ts;
   bit                m_en_low;
   logic [15:0]       m_count;
   logic [31:0]       m_ts;
   logic [7:0]        m_len;
   logic [15:0]       m_flags;
   bit                m_idle;
   bit                rnd_mode;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last    = NUM_CH - 1;
      m_sticky  = '0;
      m_prev_ts = '0;
      m_en_low  = 1'b0;
      m_count   = '0;
      m_ts      = '0;
      m_len     = '0;
      m_flags   = '0;
      m_idle    = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0; pkt_done = 1'b0; ch_overflow = '0;
      bus.m_tready = 1'b0; bus.ch_tvalid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      check_val("rst_tvalid", bus.m_tvalid, 0);
      check_val("rst_tlast", bus.m_tlast, 0);
      check_val("rst_tready", bus.ch_tready, 0);
      check_val("rst_tdata", bus.m_tdata, 0);
      check_val("rst_tuser", bus.m_tuser, 0);
      check_val("rst_ts", timestamp_latched, 0);
      check_val("rst_len", capture_len_out, 0);
      check_val("rst_flags", error_flags, 0);
      check_val("rst_count", pkt_count, 0);
      check_val("rst_busy", busy, 0);
      @(posedge clk); #1;
   endtask

   function automatic logic [NUM_CH-1:0] rnd_ovf();
      if (rnd_mode && $urandom_range(7) == 0)
         return NUM_CH'($urandom);
      return '0;
   endfunction

   // Completes the current packet with enable low so the block returns to IDLE
   task automatic finish_idle();
      enable = 1'b0; pkt_done = 1'b1;
      @(negedge clk);
      check_val("fin_busy_before", busy, 1);
      @(posedge clk); #1;
      pkt_done = 1'b0;
      m_count++;
      m_idle = 1'b1;
      @(negedge clk);
      check_val("fin_busy", busy, 0);
      check_val("fin_count", pkt_count, m_count);
      @(posedge clk); #1;
      pkt_done = 1'b1;
      @(posedge clk); #1;
      pkt_done = 1'b0;
      @(negedge clk);
      check_val("idle_done_ignored", pkt_count, m_count);
      @(posedge clk); #1;
   endtask

   // rdy_pct < 0 selects a strict 1/0 toggle of m_tready
   task automatic capture(input int len_cfg, input logic [NUM_CH-1:0] vmask, input int rdy_pct,
                          input int vld_pct, input int gap, input int en_drop, input int rst_beat,
                          input logic [NUM_CH-1:0] ovf_wait, input logic [NUM_CH-1:0] ovf_latch,
                          input logic [31:0] ts);
      int len, exp_ch, c, beats, cyc, s;
      logic v, r;
      logic [15:0] exp_flags;
      logic [31:0] exp_d;
      len    = (len_cfg == 0) ? 256 : len_cfg;
      exp_ch = -1;
      for (int k = 1; k <= NUM_CH; k++) begin
         c = (m_last + k) % NUM_CH;
         if (exp_ch < 0 && vmask[c]) exp_ch = c;
      end

      bus.ch_tvalid   = vmask;
      bus.m_tready    = 1'b0;
      capture_len_cfg = len_cfg[7:0];
      timestamp_in    = $urandom;
      ch_overflow     = rnd_ovf();
      if (m_idle) enable = 1'b1;
      else        pkt_done = 1'b1;
      @(negedge clk);
      check_val("trig_tvalid", bus.m_tvalid, 0);
      @(posedge clk); #1;
      m_sticky |= ch_overflow;
      if (!m_idle) m_count++;
      m_idle   = 1'b0;
      pkt_done = 1'b0;

      ch_overflow  = ovf_latch | rnd_ovf();
      timestamp_in = ts;
      @(negedge clk);
      check_val("arb_busy", busy, 1);
      check_val("arb_tvalid", bus.m_tvalid, 0);
      check_val("arb_count", pkt_count, m_count);
      @(posedge clk); #1;
      exp_flags              = '0;
      exp_flags[NUM_CH-1:0]  = m_sticky | ch_overflow;
      exp_flags[8]           = (m_prev_ts > ts);
      exp_flags[9]           = m_en_low;
      m_sticky  = '0;
      m_en_low  = 1'b0;
      m_prev_ts = ts;
      m_last    = exp_ch;
      m_flags   = exp_flags;
      m_ts      = ts;
      m_len     = len_cfg[7:0];
      ch_overflow  = '0;
      timestamp_in = $urandom;

      beats = 0;
      cyc   = 0;
      while (beats < len && cyc < 4000) begin
         v = ($urandom_range(99) < vld_pct);
         r = (rdy_pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < rdy_pct);
         bus.ch_tvalid         = vmask;
         bus.ch_tvalid[exp_ch] = v;
         if (en_drop >= 0 && beats >= en_drop) enable = 1'b0;
         ch_overflow = rnd_ovf();
         pkt_done    = rnd_mode && ($urandom_range(7) == 0);
         if (beats == rst_beat) begin
            rst = 1'b1;
            r   = 1'b0;
         end
         bus.m_tready = r;
         @(negedge clk);
         if (cyc == 0) begin
            check_val("lat_ts", timestamp_latched, m_ts);
            check_val("lat_len", capture_len_out, m_len);
            check_val("lat_flags", error_flags, m_flags);
         end
         check_val("s_tvalid", bus.m_tvalid, v);
         check_val("s_tuser", bus.m_tuser, exp_ch);
         check_val("s_tlast", bus.m_tlast, beats == len - 1);
         check_val("s_tready", bus.ch_tready, r ? (1 << exp_ch) : 0);
         if (v) begin
            s     = seq[exp_ch];
            exp_d = {8'(exp_ch), s[23:0]};
            check_val("s_tdata", bus.m_tdata, exp_d);
         end
         @(posedge clk); #1;
         pkt_done = 1'b0;
         if (rst) begin
            rst = 1'b0; enable = 1'b0; bus.m_tready = 1'b0; ch_overflow = '0;
            model_reset();
            @(negedge clk);
            check_val("mr_tvalid", bus.m_tvalid, 0);
            check_val("mr_tlast", bus.m_tlast, 0);
            check_val("mr_tready", bus.ch_tready, 0);
            check_val("mr_busy", busy, 0);
            check_val("mr_count", pkt_count, 0);
            check_val("mr_ts", timestamp_latched, 0);
            @(posedge clk); #1;
            $display("pkt ch=%0d len=%0d reset after %0d beats", exp_ch, len, beats);
            return;
         end
         if (!enable) m_en_low = 1'b1;
         m_sticky |= ch_overflow;
         ch_overflow = '0;
         if (v && r) begin
            seq[exp_ch]++;
            beats++;
         end
         cyc++;
      end
      if (cyc >= 4000) check_val("stream_bound", beats, len);

      for (int g = 0; g < gap; g++) begin
         bus.ch_tvalid = vmask;
         bus.m_tready  = 1'($urandom_range(1));
         ch_overflow   = (g == 0) ? (ovf_wait | rnd_ovf()) : rnd_ovf();
         @(negedge clk);
         check_val("w_tvalid", bus.m_tvalid, 0);
         check_val("w_tlast", bus.m_tlast, 0);
         check_val("w_tready", bus.ch_tready, 0);
         check_val("w_ts", timestamp_latched, m_ts);
         check_val("w_len", capture_len_out, m_len);
         check_val("w_flags", error_flags, m_flags);
         @(posedge clk); #1;
         m_sticky |= ch_overflow;
         ch_overflow = '0;
      end
      $display("pkt ch=%0d len=%0d beats=%0d flags=0x%04h ts=0x%08h", exp_ch, len, beats, exp_flags, ts);
   endtask

   initial begin
      int len_cfg, drop;
      logic [NUM_CH-1:0] vm;
      logic [31:0] ts;
      for (int i = 0; i < NUM_CH; i++) seq[i] = 0;
      rnd_mode = 1'b0;
      timestamp_in = '0; capture_len_cfg = '0;
      do_reset();

      // single channel, basic sideband
      capture(4, 4'b0010, 100, 100, 2, -1, -1, '0, '0, 32'h1000);
      check_val("t1_ts", timestamp_latched, 32'h1000);
      check_val("t1_len", capture_len_out, 4);
      finish_idle();
      check_val("t1_count", pkt_count, 1);

      // round robin over all channels from a fresh reset
      do_reset();
      for (int p = 0; p < 5; p++)
         capture(2, 4'b1111, 100, 100, 2, -1, -1, '0, '0, 32'h100 * (p + 1));

      // 256-beat capture with a toggling ready
      capture(0, 4'b0001, -1, 100, 2, -1, -1, '0, '0, 32'h1800);

      // overflow accounting
      capture(3, 4'b0001, 100, 100, 2, -1, -1, 4'b0100, '0, 32'h2000);
      capture(3, 4'b0001, 100, 100, 2, -1, -1, '0, 4'b1000, 32'h3000);
      check_val("ovf_flags", error_flags, 16'h000C);
      capture(3, 4'b0001, 100, 100, 2, -1, -1, '0, '0, 32'h4000);
      check_val("ovf_cleared", error_flags, 16'h0000);

      // enable dropped mid-capture
      capture(8, 4'b0010, 100, 100, 2, 2, -1, '0, '0, 32'h5000);
      finish_idle();
      capture(4, 4'b0010, 100, 100, 2, -1, -1, '0, '0, 32'h6000);
      check_val("en_low_flag", error_flags[9], 1);

      // reset in the middle of a capture
      capture(8, 4'b0001, 100, 100, 1, -1, 3, '0, '0, 32'h7000);

      rnd_mode = 1'b1;
      for (int p = 0; p < 40; p++) begin
         vm = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
         len_cfg = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 12);
         drop = ($urandom_range(4) == 0) ? $urandom_range(0, 7) : -1;
         ts = ($urandom_range(1) == 0) ? $urandom : m_prev_ts + $urandom_range(1, 500);
         capture(len_cfg, vm, $urandom_range(30, 100), $urandom_range(50, 100),
                 $urandom_range(1, 4), drop, -1, '0, '0, ts);
         if (drop >= 0) finish_idle();
      end
      rnd_mode = 1'b0;
      if (!m_idle) finish_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/capture_scheduler.md
Name: capture_scheduler

Overview:
- Sits directly upstream of the AXI-stream packetizer and sequences captures into it.
- Arbitrates round-robin between NUM_CH channel sample streams and grants one channel per capture.
- Latches the per-packet sideband (timestamp, sample count, error flags) at capture start and holds it until the packetizer reports the packet complete.
- Forwards exactly capture_len samples with tlast on the final sample.

Parameters:
- NUM_CH, 4, number of channel sample streams; legal range 2..8.
- DATA_W, 32, sample width.
- USER_W, 8, tuser width; carries the channel id in [3:0], upper bits are 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  capture enable.
- timestamp_in  in  32  free-running timestamp counter.
- capture_len_cfg  in  8  samples per capture; 0 means 256.
- ch_tdata  in  NUM_CH*DATA_W  channel samples; channel i occupies [i*DATA_W +: DATA_W].
- ch_tvalid  in  NUM_CH  per-channel valid.
- ch_tready  out  NUM_CH  per-channel ready.
- ch_overflow  in  NUM_CH  single-cycle overflow pulses from the channel FIFOs.
- m_tdata  out  DATA_W  sample to the packetizer.
- m_tuser  out  USER_W  granted channel id.
- m_tvalid  out  1  valid to the packetizer.
- m_tlast  out  1  last sample of the capture.
- m_tready  in  1  ready from the packetizer.
- pkt_done  in  1  pulse on the packetizer's final output beat (DONE-state handshake).
- timestamp_latched  out  32  timestamp for the current packet.
- capture_len_out  out  8  sample count for the current packet.
- error_flags  out  16  error flags for the current packet.
- busy  out  1  high in any state other than IDLE.
- pkt_count  out  16  completed packets; wraps at 0xFFFF to 0.

Behaviour:
- Reset values:
  - State IDLE.
  - All ch_tready = 0, m_tvalid = 0, m_tlast = 0.
  - m_tdata, m_tuser, timestamp_latched, capture_len_out, error_flags, pkt_count = 0.
  - last_grant = NUM_CH-1, so the first grant search starts at ch0.
  - Sticky overflow register = 0.
- States: IDLE, ARB, STREAM, WAIT_DONE.
- IDLE:
  - enable = 1 -> ARB on the next cycle.
- ARB:
  - Search ch_tvalid starting at (last_grant+1) mod NUM_CH; the first set bit wins.
  - No bit set: stay in ARB, or go to IDLE if enable = 0.
  - On a win, all in the same cycle:
    - grant <= winner; last_grant <= winner.
    - timestamp_latched <= timestamp_in.
    - capture_len_out <= capture_len_cfg.
    - length counter target = capture_len_cfg, with 0 mapped to 256 (9-bit counter).
    - error_flags latched (see bits below); sticky register cleared.
    - -> STREAM.
  - Latency: ch_tvalid seen in ARB -> first m_tvalid exactly 1 cycle later.
- STREAM:
  - Combinational pass-through of the granted channel only:
    - m_tvalid = ch_tvalid[grant]; m_tdata = the granted channel's slice.
    - m_tuser = grant zero-extended.
    - ch_tready[grant] = m_tready; all other ch_tready = 0.
  - The sample counter increments on each m_tvalid && m_tready beat.
  - m_tlast = 1 while the counter equals target-1.
  - A handshake with m_tlast = 1 -> WAIT_DONE.
  - enable falling mid-capture does not truncate: the capture always completes its full length.
- WAIT_DONE:
  - All ch_tready = 0; m_tvalid = 0.
  - timestamp_latched, capture_len_out and error_flags stay stable.
  - pkt_done = 1 -> pkt_count += 1, then ARB if enable = 1, else IDLE.
  - A pkt_done pulse seen in any other state is ignored.
- error_flags bits, captured at latch:
  - [NUM_CH-1:0] = sticky overflow OR'd with the current-cycle ch_overflow. A pulse in the latch cycle counts toward this packet and is not carried over.
  - [8] = timestamp_in wrapped (previous latched value > timestamp_in).
  - [9] = enable was low during the previous capture's STREAM phase.
  - All other bits = 0.
- The sticky overflow register accumulates ch_overflow in every state except the latch cycle.
- Reset mid-operation, any state: returns to reset values in 1 cycle and no m_tlast is emitted. The downstream packetizer is reset by the same rst.

Test Plan:
- NUM_CH=4, capture_len_cfg=4, ch1 only valid, m_tready=1, timestamp_in=0x1000 at ARB -> 4 beats with m_tuser=1, m_tlast on beat 4, timestamp_latched=0x1000, capture_len_out=4; pkt_done -> pkt_count=1.
- All 4 channels valid continuously, len=2, pkt_done 3 cycles after each tlast -> grant order 0,1,2,3,0; no ch_tready ever high for an ungranted channel.
- len=0, ch0 valid, m_tready toggling 1/0 -> exactly 256 beats accepted, tlast on beat 256, no beat dropped or duplicated during stalls.
- ch2 overflow pulse in WAIT_DONE, plus ch3 pulse in the latch cycle -> next packet's error_flags=0x000C; the following packet's flags=0x0000.
- enable dropped at beat 2 of 8 -> all 8 beats still sent; after pkt_done go to IDLE with busy=0; the next packet has error_flags[9]=1.
- rst asserted at beat 3 of 8 -> the next cycle has m_tvalid=0, ch_tready=0, state IDLE, pkt_count=0.
